// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED owner arbiter: owner encoding,
// register map and reset values.
package led_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_SW   = 2'd1,
        OWNER_DIP  = 2'd2,
        OWNER_BTN  = 2'd3
    } owner_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_SW_LED  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_BTN_PAT = 2'd3;

    localparam int CTRL_SW_EN  = 0;
    localparam int CTRL_DIP_EN = 1;
    localparam int CTRL_BTN_EN = 2;

    localparam logic [2:0]  CTRL_RESET    = 3'b000;
    localparam logic [7:0]  SW_LED_RESET  = 8'h00;
    localparam logic [15:0] BTN_PAT_RESET = 16'hF00F;

    // Owner used whenever no button pattern holds the LEDs.
    function automatic owner_e fallback_owner(input logic [2:0] ctrl);
        owner_e owner;
        if (ctrl[CTRL_SW_EN]) begin
            owner = OWNER_SW;
        end else if (ctrl[CTRL_DIP_EN]) begin
            owner = OWNER_DIP;
        end else begin
            owner = OWNER_IDLE;
        end
        return owner;
    endfunction

endpackage

// File: rtl/led_owner_arbiter_if.sv
// Avalon-MM slave port of the LED owner arbiter, as seen from the HPS
// lightweight bridge (master) and the arbiter (slave).
interface led_owner_arbiter_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and a one-cycle
// press pulse when the accepted level turns to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          pressed_s;

    assign pressed_s = ~sync_r[1];

    // Synchronize, then accept a new level only after it stayed unchanged
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= 2'b11;
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], key_n};
            press_r <= 1'b0;
            if (pressed_s == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= pressed_s;
                press_r <= pressed_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/led_owner_arbiter.sv
// Shares the 8-bit LED conduit between the HPS pattern register, transient
// button patterns and the live DIP switches, with an Avalon-MM control port.
module led_owner_arbiter
    import led_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    led_owner_arbiter_if.slave  avs,
    input  logic [1:0]          button,
    input  logic [3:0]          dipsw,
    output logic [7:0]          led
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [2:0]    ctrl_r;
    logic [7:0]    sw_led_r;
    logic [15:0]   btn_pat_r;
    logic [7:0]    press_cnt_r;
    logic [3:0]    dip_meta_r;
    logic [3:0]    dip_sync_r;
    logic [31:0]   readdata_r;
    logic [7:0]    led_r;

    owner_e        state_r;
    owner_e        state_next_s;
    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_next_s;
    logic [7:0]    btn_led_r;
    logic [7:0]    btn_led_next_s;

    logic [1:0]    key_level_s;
    logic [1:0]    key_press_s;
    logic          btn_en_s;
    logic [31:0]   status_s;
    logic [31:0]   read_mux_s;
    logic          unused_wdata_s;

    assign unused_wdata_s = ^avs.avs_writedata[31:16];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk   (clk),
        .reset (reset),
        .key_n (button[0]),
        .level (key_level_s[0]),
        .press (key_press_s[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk   (clk),
        .reset (reset),
        .key_n (button[1]),
        .level (key_level_s[1]),
        .press (key_press_s[1])
    );

    assign btn_en_s = ctrl_r[CTRL_BTN_EN];
    assign status_s = {16'h0000, press_cnt_r, dip_sync_r, key_level_s[1], key_level_s[0], state_r};

    // Read multiplexer; unused bits read as zero.
    always_comb begin
        read_mux_s = 32'h0000_0000;
        case (avs.avs_address)
            ADDR_CTRL:    read_mux_s = {29'd0, ctrl_r};
            ADDR_SW_LED:  read_mux_s = {24'd0, sw_led_r};
            ADDR_STATUS:  read_mux_s = status_s;
            ADDR_BTN_PAT: read_mux_s = {16'd0, btn_pat_r};
            default:      read_mux_s = 32'h0000_0000;
        endcase
    end

    // Register file writes and read-data capture; a same-cycle read sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= CTRL_RESET;
            sw_led_r   <= SW_LED_RESET;
            btn_pat_r  <= BTN_PAT_RESET;
            readdata_r <= 32'h0000_0000;
        end else begin
            if (avs.avs_write) begin
                case (avs.avs_address)
                    ADDR_CTRL:    ctrl_r    <= avs.avs_writedata[2:0];
                    ADDR_SW_LED:  sw_led_r  <= avs.avs_writedata[7:0];
                    ADDR_BTN_PAT: btn_pat_r <= avs.avs_writedata[15:0];
                    default:      ;
                endcase
            end
            if (avs.avs_read) begin
                readdata_r <= read_mux_s;
            end
        end
    end

    // DIP synchronizer and press counter (counts every event, enabled or not).
    always_ff @(posedge clk) begin
        if (reset) begin
            dip_meta_r  <= 4'h0;
            dip_sync_r  <= 4'h0;
            press_cnt_r <= 8'h00;
        end else begin
            dip_meta_r  <= dipsw;
            dip_sync_r  <= dip_meta_r;
            press_cnt_r <= press_cnt_r + {7'd0, key_press_s[0]} + {7'd0, key_press_s[1]};
        end
    end

    // Owner next state: a press grabs the LEDs (key1 wins a tie) and
    // restarts the hold; BTN lasts exactly HOLD_CYCLES cycles.
    always_comb begin
        state_next_s   = state_r;
        hold_next_s    = hold_r;
        btn_led_next_s = btn_led_r;
        if (btn_en_s && (key_press_s != 2'b00)) begin
            state_next_s = OWNER_BTN;
            hold_next_s  = HW'(HOLD_CYCLES);
            if (key_press_s[1]) begin
                btn_led_next_s = btn_pat_r[15:8];
            end else begin
                btn_led_next_s = btn_pat_r[7:0];
            end
        end else if ((state_r == OWNER_BTN) && btn_en_s && (hold_r > HW'(1))) begin
            hold_next_s = hold_r - HW'(1);
        end else begin
            state_next_s = fallback_owner(ctrl_r);
            hold_next_s  = {HW{1'b0}};
        end
    end

    // Owner state, hold counter and latched button pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= OWNER_IDLE;
            hold_r    <= {HW{1'b0}};
            btn_led_r <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            hold_r    <= hold_next_s;
            btn_led_r <= btn_led_next_s;
        end
    end

    // LED register driven from the current owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'h00;
        end else begin
            case (state_r)
                OWNER_IDLE: led_r <= 8'h00;
                OWNER_SW:   led_r <= sw_led_r;
                OWNER_DIP:  led_r <= {4'h0, dip_sync_r};
                OWNER_BTN:  led_r <= btn_led_r;
                default:    led_r <= 8'h00;
            endcase
        end
    end

    assign led              = led_r;
    assign avs.avs_readdata = readdata_r;

endmodule

// File: tb/tb_led_owner_arbiter.sv
// Directed and randomized checks of led_owner_arbiter against a cycle-indexed
// reference model built from the register map and ownership rules.
module tb_led_owner_arbiter;

    localparam int DB   = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] button;
    logic [3:0] dipsw;
    logic [7:0] led;

    led_owner_arbiter_if bus ();

    led_owner_arbiter #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .avs    (bus.slave),
        .button (button),
        .dipsw  (dipsw),
        .led    (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model values visible in the current cycle (keys in pressed=1 sense).
    logic [2:0]  m_ctrl;
    logic [7:0]  m_sw;
    logic [15:0] m_pat;
    logic [7:0]  m_cnt;
    logic [1:0]  m_owner;
    logic [7:0]  m_btn_led;
    int          m_btn_end;
    logic [7:0]  m_led;
    logic [31:0] m_rd;
    logic [1:0]  m_raw_d1, m_sync, m_acc, m_evt;
    logic [3:0]  m_dip_d1, m_dip;
    logic [1:0]  win [DB];
    int          win_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] fallback(input logic [2:0] c);
        return c[0] ? 2'd1 : (c[1] ? 2'd2 : 2'd0);
    endfunction

    task automatic tick();
        logic [2:0]  n_ctrl;
        logic [7:0]  n_sw, n_cnt, n_btn_led, n_led;
        logic [15:0] n_pat;
        logic [1:0]  n_owner, n_raw_d1, n_sync, n_acc, n_evt;
        logic [3:0]  n_dip_d1, n_dip;
        logic [31:0] n_rd, status;
        int          n_btn_end;
        bit          same;
        if (reset) begin
            n_ctrl = 3'd0; n_sw = 8'h00; n_pat = 16'hF00F; n_cnt = 8'h00;
            n_owner = 2'd0; n_btn_led = 8'h00; n_btn_end = 0; n_led = 8'h00; n_rd = 32'h0;
            n_raw_d1 = 2'b00; n_sync = 2'b00; n_acc = 2'b00; n_evt = 2'b00;
            n_dip_d1 = 4'h0; n_dip = 4'h0; win_n = 0;
        end else begin
            status = {16'h0000, m_cnt, m_dip, m_acc[1], m_acc[0], m_owner};
            n_ctrl = m_ctrl; n_sw = m_sw; n_pat = m_pat; n_rd = m_rd;
            if (bus.avs_read) begin
                case (bus.avs_address)
                    2'd0:    n_rd = {29'd0, m_ctrl};
                    2'd1:    n_rd = {24'd0, m_sw};
                    2'd2:    n_rd = status;
                    default: n_rd = {16'd0, m_pat};
                endcase
            end
            if (bus.avs_write) begin
                case (bus.avs_address)
                    2'd0:    n_ctrl = bus.avs_writedata[2:0];
                    2'd1:    n_sw = bus.avs_writedata[7:0];
                    2'd3:    n_pat = bus.avs_writedata[15:0];
                    default: ;
                endcase
            end
            n_raw_d1 = ~button; n_sync = m_raw_d1;
            n_dip_d1 = dipsw;   n_dip = m_dip_d1;
            // Accept a level once the last DB synchronized samples all agree on it.
            for (int i = DB - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = m_sync;
            if (win_n < DB) win_n++;
            n_acc = m_acc; n_evt = 2'b00;
            for (int k = 0; k < 2; k++) begin
                same = (win_n == DB);
                for (int i = 0; i < DB; i++) if (win[i][k] != m_sync[k]) same = 1'b0;
                if (same && (m_sync[k] != m_acc[k])) begin
                    n_acc[k] = m_sync[k];
                    n_evt[k] = m_sync[k];
                end
            end
            n_cnt = m_cnt + 8'(m_evt[0]) + 8'(m_evt[1]);
            case (m_owner)
                2'd0:    n_led = 8'h00;
                2'd1:    n_led = m_sw;
                2'd2:    n_led = {4'h0, m_dip};
                default: n_led = m_btn_led;
            endcase
            n_btn_end = m_btn_end; n_btn_led = m_btn_led;
            if (m_ctrl[2] && (m_evt != 2'b00)) begin
                n_owner = 2'd3;
                n_btn_end = cyc + HOLD;
                n_btn_led = m_evt[1] ? m_pat[15:8] : m_pat[7:0];
            end else if ((m_owner == 2'd3) && m_ctrl[2] && (cyc + 1 <= m_btn_end)) begin
                n_owner = 2'd3;
            end else begin
                n_owner = fallback(m_ctrl);
            end
        end
        @(posedge clk);
        #1;
        m_ctrl = n_ctrl; m_sw = n_sw; m_pat = n_pat; m_cnt = n_cnt; m_owner = n_owner;
        m_btn_led = n_btn_led; m_btn_end = n_btn_end; m_led = n_led; m_rd = n_rd;
        m_raw_d1 = n_raw_d1; m_sync = n_sync; m_acc = n_acc; m_evt = n_evt;
        m_dip_d1 = n_dip_d1; m_dip = n_dip;
        cyc++;
        chk("model_led", {24'd0, led}, {24'd0, m_led});
        chk("model_rdata", bus.avs_readdata, m_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
        tick();
        bus.avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.avs_read = 1'b1; bus.avs_address = a;
        tick();
        bus.avs_read = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic wait_led(input logic [7:0] v, input int budget, input string tag);
        int n = 0;
        while ((led !== v) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, {24'd0, led}, {24'd0, v});
    endtask

    task automatic run_len(input logic [7:0] v, output int len);
        len = 0;
        while ((led === v) && (len < 40)) begin
            len++;
            tick();
        end
    endtask

    logic [31:0] d;
    int          len;

    initial begin
        reset = 1'b1; button = 2'b11; dipsw = 4'h0;
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_address = 2'd0; bus.avs_writedata = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_led", {24'd0, led}, 32'h0);
        rd(2'd2, d); chk("reset_status", d, 32'h0000_0000);
        rd(2'd3, d); chk("reset_btn_pat", d, 32'h0000_F00F);

        // HPS pattern ownership
        wr(2'd1, 32'hA5);
        wr(2'd0, 32'h1);
        repeat (2) tick();
        chk("sw_led", {24'd0, led}, 32'hA5);
        rd(2'd2, d); chk("owner_sw", {30'd0, d[1:0]}, 32'd1);
        wr(2'd0, 32'h0);
        repeat (2) tick();
        chk("idle_led", {24'd0, led}, 32'h0);

        // DIP ownership and SW priority
        wr(2'd0, 32'h2);
        dipsw = 4'hA;
        repeat (3) tick();
        chk("dip_led", {24'd0, led}, 32'h0A);
        wr(2'd0, 32'h3);
        repeat (2) tick();
        chk("sw_over_dip", {24'd0, led}, 32'hA5);

        // Read and write of the same register in one cycle returns the old value
        bus.avs_read = 1'b1; bus.avs_write = 1'b1;
        bus.avs_address = 2'd1; bus.avs_writedata = 32'h3C;
        tick();
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        chk("rw_same_old", bus.avs_readdata, 32'hA5);
        wr(2'd1, 32'hA5);

        // Glitch on key0 is rejected
        wr(2'd0, 32'h5);
        button = 2'b10; repeat (2) tick();
        button = 2'b11; repeat (10) tick();
        rd(2'd2, d); chk("glitch_count", {24'd0, d[15:8]}, 32'd0);

        // Valid key0 press: pattern for exactly HOLD cycles
        button = 2'b10; repeat (6) tick();
        button = 2'b11;
        wait_led(8'h0F, 20, "key0_pattern");
        run_len(8'h0F, len);
        chk("key0_hold_len", len, HOLD);
        chk("key0_after_hold", {24'd0, led}, 32'hA5);
        rd(2'd2, d); chk("key0_count", {24'd0, d[15:8]}, 32'd1);

        // Both keys together: key1 wins; then key0 re-press restarts the hold
        button = 2'b00; repeat (4) tick();
        button = 2'b11;
        wait_led(8'hF0, 20, "both_key1_wins");
        button = 2'b10; repeat (6) tick();
        button = 2'b11;
        wait_led(8'h0F, 20, "repress_pattern");
        run_len(8'h0F, len);
        chk("repress_hold_len", len, HOLD);
        chk("repress_after_hold", {24'd0, led}, 32'hA5);
        rd(2'd2, d); chk("both_count", {24'd0, d[15:8]}, 32'd4);

        // Reset in the middle of a button hold
        dipsw = 4'h0;
        button = 2'b10; repeat (6) tick();
        button = 2'b11;
        wait_led(8'h0F, 20, "pre_reset_pattern");
        tick();
        reset = 1'b1;
        tick();
        chk("reset_mid_btn_led", {24'd0, led}, 32'h0);
        reset = 1'b0;
        tick();
        rd(2'd0, d); chk("reset_ctrl", d, 32'h0);
        rd(2'd3, d); chk("reset_btn_pat2", d, 32'h0000_F00F);
        rd(2'd2, d); chk("reset_status2", d, 32'h0);

        // Press counter wraps after 256 presses
        for (int i = 0; i < 256; i++) begin
            button = (i % 2 == 0) ? 2'b10 : 2'b01;
            repeat (6) tick();
            button = 2'b11;
            repeat (6) tick();
            if (i == 254) begin
                rd(2'd2, d); chk("count_255", {24'd0, d[15:8]}, 32'hFF);
            end
        end
        rd(2'd2, d); chk("count_wrap", {24'd0, d[15:8]}, 32'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.avs_write = ($urandom_range(0, 7) == 0);
            bus.avs_read = ($urandom_range(0, 3) == 0);
            bus.avs_address = 2'($urandom_range(0, 3));
            bus.avs_writedata = $urandom;
            if ($urandom_range(0, 9) == 0) button = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) dipsw = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0; bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
